// File: rtl/handshake_share_pkg.sv
// Shared types and helpers for the handshake share arbiter: index width and
// the round-robin pick used by the issue-side arbiter.
package handshake_share_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask at or after ptr, wrapping within n requesters.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                         input int ptr, input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (k < n && !r.found && mask[j[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_share_arbiter_order_fifo.sv
// Order FIFO holding the requester index of every outstanding token, so that
// in-order results can be routed back to their issuer.
module handshake_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/handshake_share_arbiter.sv
// Round-robin sharing of one in-order handshake unit among NUM_REQ requesters.
// Define HANDSHAKE_SHARE_ISSUE_REG_EN to insert a one-entry issue register slice.
module handshake_share_arbiter
    import handshake_share_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ins,
    input  logic [NUM_REQ-1:0]            ins_valid,
    output logic [NUM_REQ-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]         issue_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    input  logic [DATA_WIDTH-1:0]         result_data,
    input  logic                          result_valid,
    output logic                          result_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] outs,
    output logic [NUM_REQ-1:0]            outs_valid,
    input  logic [NUM_REQ-1:0]            outs_ready
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic                  full;
    logic                  empty;
    logic [IDX_W-1:0]      head;
    logic                  pop;
    logic                  locked;
    logic [IDX_W-1:0]      lock_idx;
    logic [IDX_W-1:0]      last_winner;
    logic [IDX_W-1:0]      next_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      winner;
    logic [MAX_REQ-1:0]    elig_mask;
    rr_pick_t              pick;
    logic                  arb_valid;
    logic                  arb_ready;
    logic                  arb_fire;
    logic [DATA_WIDTH-1:0] arb_data;

    always_comb begin
        elig_mask = '0;
        elig_mask[NUM_REQ-1:0] = full ? '0 : ins_valid;
        next_ptr = (last_winner == IDX_W'(NUM_REQ-1)) ? '0 : last_winner + IDX_W'(1);
        pick = rr_pick(elig_mask, int'(next_ptr), NUM_REQ);
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.idx == MAX_IDX_W'(i)) pick_idx = IDX_W'(i);
        end
        // A stalled grant stays put so the offered token cannot change under the unit.
        winner    = locked ? lock_idx : pick_idx;
        arb_valid = locked ? (ins_valid[lock_idx] && !full) : pick.found;
        arb_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) arb_data = ins[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef HANDSHAKE_SHARE_ISSUE_REG_EN
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    assign arb_ready   = (!vld_p1 || issue_ready) && !rst;
    assign issue_valid = vld_p1;
    assign issue_data  = data_p1;

    // Stage p0 -> p1: issue register slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              vld_p1 <= 1'b0;
        else if (arb_fire)    vld_p1 <= 1'b1;
        else if (issue_ready) vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (arb_fire) data_p1 <= arb_data;
    end
`else
    assign arb_ready   = issue_ready && !rst;
    assign issue_valid = arb_valid && !rst;
    assign issue_data  = arb_data;
`endif

    assign arb_fire = arb_valid && arb_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ins_ready[i] = arb_fire && (winner == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked      <= 1'b0;
            lock_idx    <= '0;
            last_winner <= IDX_W'(NUM_REQ-1);
        end else if (arb_fire) begin
            locked      <= 1'b0;
            last_winner <= winner;
        end else if (arb_valid) begin
            locked      <= 1'b1;
            lock_idx    <= winner;
        end
    end

    handshake_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (arb_fire),
        .push_data (winner),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign result_ready = !empty && outs_ready[head] && !rst;
    assign pop          = result_valid && result_ready;
    assign outs         = {NUM_REQ{result_data}};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            outs_valid[i] = result_valid && !empty && !rst && (head == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_handshake_share_arbiter.sv
// Self-checking bench for handshake_share_arbiter (default build or with
// HANDSHAKE_SHARE_ISSUE_REG_EN defined).
module tb_handshake_share_arbiter;

    localparam int N = 3;
    localparam int W = 32;
    localparam int D = 4;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   ins;
    logic [N-1:0]     ins_valid;
    logic [N-1:0]     ins_ready;
    logic [W-1:0]     issue_data;
    logic             issue_valid;
    logic             issue_ready;
    logic [W-1:0]     result_data;
    logic             result_valid;
    logic             result_ready;
    logic [N*W-1:0]   outs;
    logic [N-1:0]     outs_valid;
    logic [N-1:0]     outs_ready;

    int n_chk  = 0;
    int n_fail = 0;

    handshake_share_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (W),
        .ORDER_DEPTH (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins          (ins),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .issue_data   (issue_data),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .outs         (outs),
        .outs_valid   (outs_valid),
        .outs_ready   (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: owners of outstanding tokens kept as a plain queue.
    int           m_last   = N-1;
    bit           m_locked = 0;
    int           m_lock   = 0;
    int           m_q[$];
    bit           m_sv     = 0;
    logic [W-1:0] m_sd     = '0;

    bit           e_arb_v = 0, e_iv = 0, e_rr = 0, e_push = 0, e_pop = 0, e_fire = 0;
    int           e_win = 0;
    logic [W-1:0] e_id = '0, e_arb_d = '0;
    logic [N-1:0] e_insr = '0, e_ov = '0;

    logic [W-1:0] unit_q[$];
    logic [W-1:0] iss_log[$];
    logic [N-1:0] ov_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        bit full;
        bit accept;
        int h;
        full    = (m_q.size() == D);
        e_arb_v = 0;
        e_win   = 0;
        if (m_locked) begin
            e_win   = m_lock;
            e_arb_v = ins_valid[m_lock] && !full;
        end else if (!full) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (!e_arb_v && ins_valid[j]) begin
                    e_arb_v = 1;
                    e_win   = j;
                end
            end
        end
        e_arb_d = ins[e_win*W +: W];
`ifdef HANDSHAKE_SHARE_ISSUE_REG_EN
        accept = !m_sv || issue_ready;
        e_iv   = m_sv;
        e_id   = m_sd;
`else
        accept = issue_ready;
        e_iv   = e_arb_v;
        e_id   = e_arb_d;
`endif
        e_push = e_arb_v && accept;
        e_insr = e_push ? N'(1 << e_win) : '0;
        e_fire = e_iv && issue_ready;
        h = 0;
        if (m_q.size() > 0) h = m_q[0];
        e_rr  = (m_q.size() > 0) && outs_ready[h];
        e_ov  = (result_valid && m_q.size() > 0) ? N'(1 << h) : '0;
        e_pop = result_valid && e_rr;
    endfunction

    // Model state update on each clock edge; reset acts asynchronously.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_last = N-1; m_locked = 0; m_lock = 0; m_sv = 0;
            m_q.delete(); unit_q.delete();
            e_arb_v = 0; e_iv = 0; e_rr = 0; e_push = 0; e_pop = 0; e_fire = 0;
            e_insr = '0; e_ov = '0;
        end else begin
            if (e_pop) begin
                void'(m_q.pop_front());
                if (unit_q.size() > 0) void'(unit_q.pop_front());
            end
            if (e_fire) unit_q.push_back(e_id);
            if (e_push) begin
                m_q.push_back(e_win);
                m_last   = e_win;
                m_locked = 0;
            end else if (e_arb_v) begin
                m_locked = 1;
                m_lock   = e_win;
            end
`ifdef HANDSHAKE_SHARE_ISSUE_REG_EN
            if (e_push) begin
                m_sv = 1;
                m_sd = e_arb_d;
            end else if (issue_ready) begin
                m_sv = 0;
            end
`endif
        end
    end

    // Compare process: every cycle, mid-period, DUT against model.
    initial forever begin
        @(negedge clk);
        chk("outs_broadcast", outs, {N{result_data}});
        if (rst) begin
            chk("rst_issue_valid", issue_valid, 0);
            chk("rst_ins_ready", ins_ready, 0);
            chk("rst_result_ready", result_ready, 0);
            chk("rst_outs_valid", outs_valid, 0);
        end else begin
            model_eval();
            chk("issue_valid", issue_valid, e_iv);
            if (e_iv) chk("issue_data", issue_data, e_id);
            chk("ins_ready", ins_ready, e_insr);
            chk("result_ready", result_ready, e_rr);
            chk("outs_valid", outs_valid, e_ov);
            if (issue_valid && issue_ready) iss_log.push_back(issue_data);
            if (result_valid && result_ready) ov_log.push_back(outs_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic [W-1:0] d);
        ins[i*W +: W] = d;
    endtask

    task automatic retire();
        for (int i = 0; i < N; i++) if (e_insr[i]) ins_valid[i] = 1'b0;
    endtask

    task automatic present_result();
        if (unit_q.size() > 0) begin
            result_valid = 1'b1;
            result_data  = unit_q[0] ^ 32'h00FF_FF00;
        end else begin
            result_valid = 1'b0;
            result_data  = $urandom;
        end
    endtask

    task automatic drain();
        int c;
        issue_ready = 1'b1;
        outs_ready  = '1;
        c = 0;
        while (c < 80 && (ins_valid != 0 || m_q.size() > 0 || unit_q.size() > 0 || m_sv)) begin
            retire();
            present_result();
            tick();
            c++;
        end
        retire();
        result_valid = 1'b0;
        chk("drain_within_bound", c < 80, 1);
    endtask

    logic [W-1:0] exp_t1_data [4];
    logic [N-1:0] exp_t1_ov   [4];
    int           n0;

    initial begin
        exp_t1_data = '{32'hA5, 32'h5A, 32'hA5, 32'h5A};
        exp_t1_ov   = '{3'b001, 3'b010, 3'b001, 3'b010};
        rst = 1'b1; ins = '0; ins_valid = '0; issue_ready = 1'b0;
        result_data = '0; result_valid = 1'b0; outs_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Two continuously valid requesters, results one cycle after issue.
        set_in(0, 32'hA5); set_in(1, 32'h5A);
        ins_valid = 3'b011; issue_ready = 1'b1; outs_ready = '1;
        iss_log.delete(); ov_log.delete();
        for (int c = 0; c < 7; c++) begin
            present_result();
            tick();
        end
        chk("t1_issue_count", iss_log.size() >= 4, 1);
        chk("t1_result_count", ov_log.size() >= 4, 1);
        for (int k = 0; k < 4; k++) begin
            if (k < iss_log.size()) chk("t1_issue_order", iss_log[k], exp_t1_data[k]);
            if (k < ov_log.size())  chk("t1_outs_valid_order", ov_log[k], exp_t1_ov[k]);
        end
        drain();

        // Stall on requester 1 while requester 0 joins.
        ins_valid = 3'b010; set_in(1, 32'h1111); issue_ready = 1'b0; result_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
`ifndef HANDSHAKE_SHARE_ISSUE_REG_EN
            @(negedge clk);
            chk("t2_stall_data", issue_data, 32'h1111);
            chk("t2_stall_valid", issue_valid, 1);
`endif
            tick();
            retire();
            if (c == 0) begin
                set_in(0, 32'h2222);
                ins_valid[0] = 1'b1;
            end
        end
        issue_ready = 1'b1;
`ifndef HANDSHAKE_SHARE_ISSUE_REG_EN
        @(negedge clk);
        chk("t2_fire_r1_data", issue_data, 32'h1111);
        chk("t2_fire_r1_ready", ins_ready, 3'b010);
`endif
        tick(); retire();
`ifndef HANDSHAKE_SHARE_ISSUE_REG_EN
        @(negedge clk);
        chk("t2_next_r0_data", issue_data, 32'h2222);
        chk("t2_next_r0_ready", ins_ready, 3'b001);
`endif
        tick(); retire();
        drain();

        // Order FIFO fills: only D tokens go out with no results returned.
        set_in(0, 32'hC0); set_in(1, 32'hC1); set_in(2, 32'hC2);
        ins_valid = 3'b111; issue_ready = 1'b1; result_valid = 1'b0;
        n0 = iss_log.size();
        repeat (6) tick();
        chk("t3_issued_count", iss_log.size() - n0, D);
        @(negedge clk);
        chk("t3_full_no_issue", issue_valid, 0);
        chk("t3_full_no_ready", ins_ready, 0);
        tick();
        result_valid = 1'b1; result_data = 32'hBEEF; outs_ready = '1;
        @(negedge clk);
        chk("t3_pop_cycle_no_ready", ins_ready, 0);
        chk("t3_pop_cycle_rr", result_ready, 1);
        tick();
        result_valid = 1'b0;
        @(negedge clk);
        chk("t3_refill_after_pop", ins_ready != 0, 1);
`ifndef HANDSHAKE_SHARE_ISSUE_REG_EN
        chk("t3_refill_issue_valid", issue_valid, 1);
`endif
        tick();
        drain();

        // Head owner backpressure, then delivery, then a spurious result.
        ins_valid = 3'b100; set_in(2, 32'h77); issue_ready = 1'b1;
        tick(); retire();
        result_valid = 1'b1; result_data = 32'h99; outs_ready = 3'b011;
        @(negedge clk);
        chk("t4_bp_result_ready", result_ready, 0);
        chk("t4_bp_outs_valid", outs_valid, 3'b100);
        tick();
        @(negedge clk);
        chk("t4_hold_result_ready", result_ready, 0);
        chk("t4_hold_outs_valid", outs_valid, 3'b100);
        tick();
        outs_ready = 3'b100;
        @(negedge clk);
        chk("t4_deliver_ready", result_ready, 1);
        chk("t4_deliver_owner", outs_valid, 3'b100);
        chk("t4_deliver_data", outs[2*W +: W], 32'h99);
        tick();
        outs_ready = '1;
        @(negedge clk);
        chk("t5_spurious_ready", result_ready, 0);
        chk("t5_spurious_outs_valid", outs_valid, 0);
        tick();
        result_valid = 1'b0;
        drain();

        // Randomized traffic in phases of differing pressure.
        for (int ph = 0; ph < 4; ph++) begin
            int pv, pr, pres, po;
            pv   = 30 + 20 * ph;
            pr   = (ph == 2) ? 30 : 80;
            pres = (ph == 1) ? 25 : 70;
            po   = (ph == 3) ? 40 : 85;
            for (int c = 0; c < 600; c++) begin
                retire();
                for (int i = 0; i < N; i++) begin
                    if (!ins_valid[i] && $urandom_range(99) < pv) begin
                        set_in(i, $urandom);
                        ins_valid[i] = 1'b1;
                    end
                end
                issue_ready = ($urandom_range(99) < pr);
                for (int i = 0; i < N; i++) outs_ready[i] = ($urandom_range(99) < po);
                if ($urandom_range(99) < pres) present_result();
                else result_valid = 1'b0;
                tick();
            end
        end
        drain();

        // Reset with tokens outstanding.
        set_in(0, 32'hA0); set_in(1, 32'hA1); set_in(2, 32'hA2);
        ins_valid = 3'b111; issue_ready = 1'b1; result_valid = 1'b0;
        repeat (3) tick();
        result_valid = 1'b1; result_data = 32'h5555; outs_ready = '1;
        rst = 1'b1;
        #1;
        chk("t6_async_issue_valid", issue_valid, 0);
        chk("t6_async_ins_ready", ins_ready, 0);
        chk("t6_async_result_ready", result_ready, 0);
        chk("t6_async_outs_valid", outs_valid, 0);
        repeat (2) tick();
        result_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_first_ready_r0", ins_ready, 3'b001);
`ifdef HANDSHAKE_SHARE_ISSUE_REG_EN
        chk("t6_slice_latency", issue_valid, 0);
        tick();
        @(negedge clk);
        chk("t6_slice_issue_valid", issue_valid, 1);
        chk("t6_slice_issue_data", issue_data, 32'hA0);
`else
        chk("t6_first_issue_valid", issue_valid, 1);
        chk("t6_first_issue_data", issue_data, 32'hA0);
`endif
        tick();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_share_arbiter.md
# handshake_share_arbiter

Round-robin scheduler that shares one handshake-channel functional unit (constant, operator, memory port) among `NUM_REQ` elastic requesters. It picks one valid requester per cycle and forwards its token to the shared unit's issue channel. It records the winner's index in an order FIFO, then routes each returning result token back to the requester that issued it. The block sits between per-requester handshake channels and a single in-order shared unit.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 32: token width on every channel.
- `ORDER_DEPTH`, 4: order-FIFO entries; power of two, ≥2; bounds outstanding tokens.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ins` in `NUM_REQ*DATA_WIDTH`: requester data; slice i = bits [i*W +: W].
- `ins_valid` in `NUM_REQ`: per-requester valid.
- `ins_ready` out `NUM_REQ`: per-requester ready.
- `issue_data` out `DATA_WIDTH`: token to the shared unit.
- `issue_valid` out 1: issue valid.
- `issue_ready` in 1: shared unit accepts.
- `result_data` in `DATA_WIDTH`: result from the shared unit, in issue order.
- `result_valid` in 1: result valid.
- `result_ready` out 1: result accepted.
- `outs` out `NUM_REQ*DATA_WIDTH`: `result_data` broadcast to every slice.
- `outs_valid` out `NUM_REQ`: one-hot valid for the owning requester.
- `outs_ready` in `NUM_REQ`: per-requester output ready.

## Operation
- **Handshake rule.** A transfer occurs on a channel when valid && ready in the same cycle. Requesters hold valid and data stable until their transfer.
- **Arbitration.**
  - Requesters are eligible only while the order FIFO is not full.
  - The search starts at `(last_winner+1) mod NUM_REQ` and wraps. After reset, `last_winner = NUM_REQ-1`, so requester 0 has top priority.
- **Grant lock.** If `issue_valid=1` and `issue_ready=0`, the current winner is latched in `lock_idx` with `locked=1`. Arbitration is frozen until that token transfers, so issue data never changes while stalled.
- **Issue.**
  - `issue_valid = any eligible valid` (or the locked requester's valid).
  - `issue_data = ins[winner]`.
  - `ins_ready[winner] = issue_ready && !full`; all other `ins_ready` bits are 0.
- **On issue transfer:**
  - push `winner` into the order FIFO;
  - `last_winner <= winner`;
  - `locked <= 0`.
- **Result routing.**
  - `head` = FIFO front index.
  - `outs_valid[i] = result_valid && !empty && head==i`.
  - `result_ready = !empty && outs_ready[head]`.
  - On a result transfer, pop the FIFO.
- **Boundary conditions.**
  - FIFO full: issue blocked even if a pop occurs in the same cycle. No combinational path from the result side to the issue side.
  - FIFO empty: `result_ready=0`. A result arriving with no outstanding issue is held indefinitely (protocol error, not dropped).
  - Simultaneous push and pop when neither full nor empty: both happen; count is unchanged.
  - Read and write pointers are `$clog2(ORDER_DEPTH)` bits and wrap naturally. Count is one bit wider.
- **Reset mid-operation.** Clears the FIFO, `locked` and `last_winner`. Outstanding results are discarded; the downstream unit must be reset together with this block.

## Timing
- Reset values:
  - `issue_valid=0`, `ins_ready=0`, `result_ready=0`, `outs_valid=0`;
  - `issue_data` and `outs` follow their inputs.
  - Reset applies asynchronously on assertion; logic restarts on the first clock after deassertion.
- Issue latency: 0 cycles in the default build (combinational `ins`→`issue`). Result latency: 0 cycles (`result`→`outs` combinational).
- Throughput: one issue and one result per cycle.
- Fairness: a continuously valid requester is granted within `NUM_REQ` issue transfers.

## Configuration
- `HANDSHAKE_SHARE_ISSUE_REG_EN` defined:
  - A one-entry register slice is inserted on the issue channel. The FIFO push happens on the `ins`→slice transfer.
  - Slice accepts when it is empty or is draining this cycle; full throughput is preserved.
  - Issue latency becomes 1 cycle, and no combinational path remains from `ins_valid` to `issue_valid`.
  - `issue_ready` still reaches `ins_ready` combinationally when the slice is full.
  - Reset empties the slice.
- Undefined: combinational issue path exactly as described in Operation.

## Structure
- Shared package `handshake_share_pkg`:
  - `IDX_W = $clog2(NUM_REQ)` helper function;
  - round-robin pick function (mask, pointer → index, found).
- One sub-module: `handshake_order_fifo`, with parameters `WIDTH=IDX_W`, `DEPTH=ORDER_DEPTH`.
  - Ports: push/pop, full/empty, head.
- The arbiter, lock and optional slice stay in the top module.

## Test plan
1. `NUM_REQ=2`, both valid continuously, `issue_ready=1`, results returned 1 cycle later with `outs_ready=3` → issue order 0,1,0,1; `outs_valid` alternates 01,10; `issue_data` matches each requester's value (`0xA5`, `0x5A`).
2. Stall: requester 1 issues with `issue_ready=0` for 3 cycles while requester 0 raises valid → `issue_data` stays requester 1's value; on the 4th cycle `issue_ready=1` fires requester 1, then requester 0 is granted next.
3. Full: `ORDER_DEPTH=4`, `result_valid=0`, 6 tokens offered → exactly 4 issued, `issue_valid=0`; one result pop → the 5th issues the following cycle, not the pop cycle.
4. Backpressure: head owner `outs_ready=0` with `result_valid=1` → `result_ready=0`, FIFO count unchanged; `outs_ready` raised → token delivered to that owner only.
5. Spurious result on an empty FIFO → `result_ready=0`, all `outs_valid` 0.
6. Reset asserted with 3 outstanding tokens → all valid/ready outputs drop immediately; after release, requester 0 wins first; repeat with `HANDSHAKE_SHARE_ISSUE_REG_EN` defined and check the 1-cycle issue latency.
